// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush and bubble injection.
// A two-entry skid buffer (main + skid) keeps in_ready a pure register output.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_hs #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          CTRL_W      = 24,
  parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              out_valid_q, in_ready_q;

  logic accept, deliver;
  logic main_load_in, main_load_skid, main_clear, skid_load;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d      = StOne;
          main_load_in = 1'b1;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          main_load_in = 1'b1;
        end else if (accept) begin
          state_d   = StTwo;
          skid_load = 1'b1;
        end else if (deliver) begin
          state_d    = StEmpty;
          main_clear = 1'b1;
        end
      end
      StTwo: begin
        if (deliver) begin
          state_d        = StOne;
          main_load_skid = 1'b1;
        end
      end
      default: begin
        state_d    = StEmpty;
        main_clear = 1'b1;
      end
    endcase
    if (flush) begin
      state_d        = StEmpty;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      main_clear     = 1'b1;
    end
  end

  // State and storage; an empty head holds the bubble pattern so outputs are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StTwo);
      if (main_clear) begin
        main_data_q <= '0;
        main_ctrl_q <= BUBBLE_CTRL;
      end else if (main_load_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (main_load_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (skid_load) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        discard;

  // A word delivered in the flush cycle is consumed, not discarded.
  assign discard = flush & ((state_q == StTwo) | ((state_q == StOne) & ~deliver));

  // Saturating stall and flush counters, cleared by reset only.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (discard && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (perf checks when PIPE_STAGE_PERF_EN is set).
module tb_pipe_stage_hs;

  localparam int unsigned   DW  = 32;
  localparam int unsigned   CW  = 24;
  localparam logic [CW-1:0] BUB = 24'h000F0F;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_stage_hs #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .BUBBLE_CTRL (BUB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = d[CW-1:0] ^ 24'h100000;
  endtask

  task automatic expect_empty(input string tag);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_data"}, out_data, 32'd0);
    check_eq({tag, "_ctrl"}, {8'd0, out_ctrl}, {8'd0, BUB});
    check_eq({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic expect_head(input string tag, input logic [DW-1:0] d, input int occ);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, out_data, d);
    check_eq({tag, "_ctrl"}, {8'd0, out_ctrl}, {8'd0, d[CW-1:0] ^ 24'h100000});
    check_eq({tag, "_occ"}, {30'd0, occupancy}, occ);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF);
    #1;
    step(); step();
    reset = 1'b0;
    drive(1'b0, 32'h0);
    expect_empty("reset");
    step();
    expect_empty("reset_idle");

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      check_eq("stream_rdy", {31'd0, in_ready}, 32'd1);
      step();
      expect_head("stream", i, 1);
    end
    drive(1'b0, 32'h0);
    step();
    expect_empty("stream_drain");

    // Back-pressure fills main then skid; third word refused.
    out_ready = 1'b0;
    drive(1'b1, 32'hA); step();
    expect_head("bp_a", 32'hA, 1);
    drive(1'b1, 32'hB); step();
    expect_head("bp_ab", 32'hA, 2);
    check_eq("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC); step();
    expect_head("bp_c_refused", 32'hA, 2);
    out_ready = 1'b1; step();
    expect_head("bp_b", 32'hB, 1);
    check_eq("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    step();
    expect_head("bp_c", 32'hC, 1);
    drive(1'b0, 32'h0); step();
    expect_empty("bp_drain");

    // Flush in TWO with a simultaneous incoming word.
    out_ready = 1'b0;
    drive(1'b1, 32'h31); step();
    drive(1'b1, 32'h32); step();
    check_eq("fl_pre_occ", {30'd0, occupancy}, 32'd2);
    drive(1'b1, 32'h55); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 32'h0);
    expect_empty("flush");
    out_ready = 1'b1; step(); step();
    expect_empty("flush_after");

    // Deliver and accept in the same cycle while in ONE.
    out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    expect_head("one_hold", 32'h10, 1);
    out_ready = 1'b1;
    drive(1'b1, 32'h20); step();
    expect_head("one_swap", 32'h20, 1);
    drive(1'b0, 32'h0); step();
    expect_empty("one_drain");

    // Reset mid-operation discards held words.
    out_ready = 1'b0;
    drive(1'b1, 32'h61); step();
    drive(1'b1, 32'h62); step();
    drive(1'b0, 32'h0);
    reset = 1'b1; step();
    reset = 1'b0;
    expect_empty("mid_reset");

`ifdef PIPE_STAGE_PERF_EN
    check_eq("perf_stall0", {16'd0, stall_cnt}, 32'd0);
    check_eq("perf_flush0", {16'd0, flush_cnt}, 32'd0);
    // Four stalled cycles, then a fifth stalled cycle that also flushes the held word.
    out_ready = 1'b0;
    drive(1'b1, 32'h77); step();
    drive(1'b0, 32'h0);
    repeat (4) step();
    flush = 1'b1; step();
    flush = 1'b0;
    check_eq("perf_stall5", {16'd0, stall_cnt}, 32'd5);
    check_eq("perf_flush1", {16'd0, flush_cnt}, 32'd1);
    // Flush with nothing held is not counted.
    flush = 1'b1; step();
    flush = 1'b0;
    check_eq("perf_flush_empty", {16'd0, flush_cnt}, 32'd1);
    drive(1'b1, 32'h78); step();
    drive(1'b0, 32'h0);
    repeat (70000) step();
    check_eq("perf_stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
